// File: rtl/resizer_rd_ctrl.sv
// Read-side controller of the width resizer. It tracks lane occupancy, drives the
// storage read pointer and feeds a registered AXI-Stream master stage.
module resizer_rd_ctrl #(
   parameter int S_KEEP_WIDTH     = 3,
   parameter int T_DATA_WIDTH     = 1,
   parameter int M_KEEP_WIDTH     = 2,
   parameter int LANE_W           = 2 + T_DATA_WIDTH,
   parameter int BUF_IN_ENTRY_SZ  = LANE_W * S_KEEP_WIDTH,
   parameter int BUF_OUT_ENTRY_SZ = LANE_W * M_KEEP_WIDTH,
   parameter int DEPTH_BITS       = BUF_IN_ENTRY_SZ * BUF_OUT_ENTRY_SZ * 2,
   parameter int DEPTH_LANES      = DEPTH_BITS / LANE_W,
   parameter int PTR_W            = $clog2(DEPTH_BITS),
   parameter int CNT_W            = $clog2(DEPTH_LANES + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 wr_en,
   output logic                                 wr_space,
   input  logic [BUF_OUT_ENTRY_SZ-1:0]          mem_dout,
   output logic [PTR_W-1:0]                     rptr,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0] m_axis_tdata,
   output logic [M_KEEP_WIDTH-1:0]              m_axis_tkeep,
   output logic                                 m_axis_tlast,
   output logic [CNT_W-1:0]                     occupancy,
   output logic                                 ovf_err
);

   localparam int SUM_W = CNT_W + 2;

   logic                                 load;
   logic [SUM_W-1:0]                     occ_sum;
   logic [CNT_W-1:0]                     occ_next;
   logic [PTR_W:0]                       rptr_sum;
   logic [PTR_W-1:0]                     rptr_next;
   logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0] beat_data;
   logic [M_KEEP_WIDTH-1:0]              beat_keep;
   logic                                 beat_last;

   // Lanes held in the output register are already counted as freed.
   assign wr_space = ((DEPTH_LANES - int'(occupancy)) >= S_KEEP_WIDTH);

   assign load = (occupancy >= CNT_W'(M_KEEP_WIDTH)) && (!m_axis_tvalid || m_axis_tready);

   // A write accepted while full saturates the count at DEPTH_LANES.
   always_comb begin
      occ_sum = SUM_W'(occupancy);
      if (wr_en) occ_sum = occ_sum + SUM_W'(S_KEEP_WIDTH);
      if (load)  occ_sum = occ_sum - SUM_W'(M_KEEP_WIDTH);
      if (occ_sum > SUM_W'(DEPTH_LANES)) occ_next = CNT_W'(DEPTH_LANES);
      else                               occ_next = occ_sum[CNT_W-1:0];
   end

   assign rptr_sum  = {1'b0, rptr} + (PTR_W+1)'(BUF_OUT_ENTRY_SZ);
   assign rptr_next = (rptr_sum >= (PTR_W+1)'(DEPTH_BITS))
                    ? PTR_W'(rptr_sum - (PTR_W+1)'(DEPTH_BITS))
                    : rptr_sum[PTR_W-1:0];

   // Lane i of a storage entry is {last, keep, data} at bits [i*LANE_W +: LANE_W].
   always_comb begin
      beat_data = '0;
      beat_keep = '0;
      beat_last = 1'b0;
      for (int unsigned i = 0; i < M_KEEP_WIDTH; i++) begin
         beat_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] = mem_dout[i*LANE_W +: T_DATA_WIDTH];
         beat_keep[i] = mem_dout[i*LANE_W + T_DATA_WIDTH];
         beat_last    = beat_last | mem_dout[i*LANE_W + T_DATA_WIDTH + 1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr          <= '0;
         occupancy     <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         ovf_err       <= 1'b0;
      end else begin
         occupancy <= occ_next;
         if (wr_en && !wr_space) ovf_err <= 1'b1;
         if (load) begin
            rptr          <= rptr_next;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= beat_data;
            m_axis_tkeep  <= beat_keep;
            m_axis_tlast  <= beat_last;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule
